// File: rtl/frame_fetch_pkg.sv
// -----------------------------------------------------------------------------
// frame_fetch_pkg
// Shared definitions for the frame_fetch pixel fetch stage:
//   - fetch_state_t : window-tracking FSM states
//   - DEF_*         : default image window geometry and framebuffer base
//   - pix_tag_t     : per-pixel record carried down the latency-matching pipe
// -----------------------------------------------------------------------------
package frame_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for frame start
    LINE = 2'd1,  // inside a window row
    GAP  = 2'd2,  // between window rows
    DONE = 2'd3   // past the last window row
  } fetch_state_t;

  localparam int unsigned DEF_X0 = 120;
  localparam int unsigned DEF_Y0 = 0;
  localparam int unsigned DEF_W  = 320;
  localparam int unsigned DEF_H  = 200;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0400;

  // Everything that must stay aligned with the returning read data.
  typedef struct packed {
    logic       fetched;
    logic       blank;
    logic       vsync;
    logic       hsync;
    logic [9:0] y;
    logic [9:0] x;
  } pix_tag_t;

endpackage

// File: rtl/frame_fetch_pixel_delay_pipe.sv
// -----------------------------------------------------------------------------
// pixel_delay_pipe
// Fixed-depth register pipe with synchronous active-low clear.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low clear of every stage
//   d      : WIDTH-bit input word
//   q      : d delayed by exactly DEPTH cycles
// Parameters: DEPTH (>= 1), WIDTH.
// -----------------------------------------------------------------------------
module pixel_delay_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: every stage is cleared, not just the output: a stale fetched tag
  // left inside the pipe would otherwise surface after reset as valid data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_fetch.sv
// -----------------------------------------------------------------------------
// frame_fetch
// Pixel fetch stage between the VGA timing controller and the graphic
// generator. Issues one framebuffer word read per in-window pixel and delays
// coordinates/syncs by RD_LAT so they meet the returning word.
//
// Ports:
//   clk, rst_n                       : pixel clock, synchronous active-low reset
//   x_in, y_in                       : current pixel coordinates (10 bit)
//   hsync_in, vsync_in, blank_in     : timing signals
//   mem_gnt                          : memory port granted this cycle
//   mem_re, mem_addr                 : read request / word address (combinational)
//   mem_rdata                        : read data, RD_LAT cycles after mem_re
//   x_out, y_out, *_out              : inputs delayed by RD_LAT
//   ReadData                         : pixel word aligned with x_out/y_out
//   underrun_cnt                     : saturating count of ungranted window cycles
//                                      (only with FRAME_FETCH_UNDERRUN_CNT_EN)
//
// Configuration macro: FRAME_FETCH_UNDERRUN_CNT_EN adds the underrun counter.
// -----------------------------------------------------------------------------
module frame_fetch
  import frame_fetch_pkg::*;
#(
  parameter int unsigned X0        = DEF_X0,
  parameter int unsigned Y0        = DEF_Y0,
  parameter int unsigned W         = DEF_W,
  parameter int unsigned H         = DEF_H,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic        mem_gnt,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic [31:0] ReadData
`ifdef FRAME_FETCH_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam logic [9:0]  X_FIRST  = 10'(X0);
  localparam logic [9:0]  X_LAST   = 10'(X0 + W - 1);
  localparam logic [9:0]  Y_FIRST  = 10'(Y0);
  localparam logic [9:0]  Y_LAST   = 10'(Y0 + H - 1);
  localparam logic [31:0] ROW_STEP = 32'(W);

  fetch_state_t state_q, state_d, state_eff;
  logic [31:0]  row_base_q, row_base_d, row_base_eff;
  logic [9:0]   col_q, col_d, col_eff;
  logic [31:0]  last_pix_q, last_pix_d;
  logic         frame_start;
  logic         in_line;

  assign frame_start = (x_in == 10'd0) && (y_in == 10'd0);

  // state_eff is the state that applies to the pixel on x_in/y_in this cycle.
  // Window entry must take effect on the first window pixel itself, so the
  // entry transitions are resolved combinationally here; the register only
  // holds where the previous pixel left us.
  // NOTE: every variable gets a default before any branch, so no latches.
  always_comb begin
    state_eff    = state_q;
    row_base_eff = row_base_q;
    col_eff      = col_q;

    if (frame_start) begin
      // Resynchronises from any state, including mid-row.
      state_eff = IDLE;
    end else if (state_q == IDLE && x_in == X_FIRST && y_in == Y_FIRST) begin
      state_eff    = LINE;
      row_base_eff = BASE_ADDR;
      col_eff      = '0;
    end else if (state_q == GAP && x_in == X_FIRST) begin
      state_eff = LINE;
      col_eff   = '0;
    end

    in_line    = (state_eff == LINE);
    state_d    = state_eff;
    row_base_d = row_base_eff;
    col_d      = col_eff;

    // Counters advance on every window cycle, granted or not, so a missed
    // grant never shifts the addresses of later pixels.
    if (in_line) begin
      col_d = col_eff + 10'd1;
      if (x_in == X_LAST) begin
        if (y_in == Y_LAST) begin
          state_d = DONE;
        end else begin
          state_d    = GAP;
          row_base_d = row_base_eff + ROW_STEP;
        end
      end
    end
  end

  assign mem_re   = in_line && mem_gnt;
  assign mem_addr = row_base_eff + {22'd0, col_eff};

  // ---------------------------------------------------------------------------
  // Latency-matching pipe
  // ---------------------------------------------------------------------------
  pix_tag_t pipe_in, pipe_out;
  logic [$bits(pix_tag_t)-1:0] pipe_out_vec;

  always_comb begin
    pipe_in.fetched = mem_re;
    pipe_in.blank   = blank_in;
    pipe_in.vsync   = vsync_in;
    pipe_in.hsync   = hsync_in;
    pipe_in.y       = y_in;
    pipe_in.x       = x_in;
  end

  pixel_delay_pipe #(
    .DEPTH (RD_LAT),
    .WIDTH ($bits(pix_tag_t))
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pipe_in),
    .q     (pipe_out_vec)
  );

  assign pipe_out  = pipe_out_vec;
  assign x_out     = pipe_out.x;
  assign y_out     = pipe_out.y;
  assign hsync_out = pipe_out.hsync;
  assign vsync_out = pipe_out.vsync;
  assign blank_out = pipe_out.blank;

  // The memory already registers mem_rdata, so selecting it here keeps the
  // word in the same cycle as its coordinates. Unfetched pixels repeat the
  // last returned word.
  always_comb begin
    last_pix_d = last_pix_q;
    if (pipe_out.fetched) begin
      last_pix_d = mem_rdata;
    end
  end

  assign ReadData = pipe_out.fetched ? mem_rdata : last_pix_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_base_q <= BASE_ADDR;
      col_q      <= '0;
      last_pix_q <= '0;
    end else begin
      state_q    <= state_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      last_pix_q <= last_pix_d;
    end
  end

`ifdef FRAME_FETCH_UNDERRUN_CNT_EN
  // ---------------------------------------------------------------------------
  // Underrun counter: window cycle without grant; saturates, cleared by reset.
  // ---------------------------------------------------------------------------
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (in_line && !mem_gnt && underrun_cnt_q != 16'hFFFF) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_cnt_q <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule
